// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_slice.sv
// Combinational 4-bit ripple-carry adder built from four full-adder bits.
module nibble_add_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single 4-bit slice.
// Optional subtract mode (sub port, a - b) is enabled by defining NIBBLE_SERIAL_SUB_EN.
module nibble_serial_add_ctrl
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output state_t           state_dbg
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = (NIB > 1) ? clog2(NIB) : 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    // Handshakes: a transfer occurs on a rising edge where valid && ready are both
    // high. in_ready is high only in IDLE; out_valid only in DONE, where sum/cout are held.

    state_t           state, next_state;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg, cout_reg;
    logic [CW-1:0]    cnt;
    logic [3:0]       slice_x, slice_y, slice_s;
    logic             slice_co;
    logic             accept, last_nib;

    assign accept   = (state == IDLE) && in_valid;
    assign last_nib = (cnt == CW'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_nib) next_state = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The single slice is shared across iterations; the counter picks the nibble.
    assign slice_x = a_reg[int'(cnt) * NIBBLE_W +: NIBBLE_W];
    assign slice_y = b_reg[int'(cnt) * NIBBLE_W +: NIBBLE_W];

    nibble_add_slice u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            a_reg <= a;
`ifdef NIBBLE_SERIAL_SUB_EN
            // Two's-complement subtract: invert b and inject a carry of one.
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
`else
            b_reg     <= b;
            carry_reg <= cin;
`endif
            cnt <= '0;
        end else if (state == RUN) begin
            sum_reg[int'(cnt) * NIBBLE_W +: NIBBLE_W] <= slice_s;
            carry_reg <= slice_co;
            if (last_nib) begin
                cout_reg <= slice_co;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign state_dbg = state;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl (WIDTH = 16, add-only build).
module tb_nibble_serial_add_ctrl;
    import nibble_serial_pkg::*;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    state_t           state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT in IDLE; returns at the negedge where out_valid
    // is first seen, with lat = number of rising edges from the accept edge onward.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci, output int lat);
        a        = av;
        b        = bv;
        cin      = ci;
        in_valid = 1'b1;
        lat      = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic ci,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        int lat;
        issue(av, bv, ci, lat);
        tests_run++;
        if (lat !== 5) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d edges, expected 5", name, lat);
        end
        tests_run++;
        if (sum !== exp_sum || cout !== exp_cout) begin
            tests_failed++;
            $display("FAIL %s result: got sum=%h cout=%b, expected sum=%h cout=%b",
                     name, sum, cout, exp_sum, exp_cout);
        end
        release_result();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_dbg !== IDLE) begin
            tests_failed++;
            $display("FAIL %s return_idle: out_valid=%b in_ready=%b state=%0d, expected 0 1 0",
                     name, out_valid, in_ready, state_dbg);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #1;
        tests_run++;
        if (state_dbg !== IDLE || in_ready !== 1'b1 || out_valid !== 1'b0 ||
            busy !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: state=%0d in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, expected 0 1 0 0 0000 0",
                     state_dbg, in_ready, out_valid, busy, sum, cout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_basic();
        run_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_carry_ripple();
        run_op("ripple_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("ripple_ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    endtask

    task automatic test_cin();
        run_op("cin_0fff", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [WIDTH-1:0] held_sum;
        logic             held_cout;
        issue(16'h00F0, 16'h0F10, 1'b0, lat);
        held_sum  = sum;
        held_cout = cout;
        tests_run++;
        if (held_sum !== 16'h1000 || held_cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_result: got sum=%h cout=%b, expected 1000 0", held_sum, held_cout);
        end
        // A new request waits while the result is stalled.
        a        = 16'h0002;
        b        = 16'h0003;
        cin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (sum !== 16'h1000 || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold cycle %0d: sum=%h cout=%b out_valid=%b in_ready=%b, expected 1000 0 1 0",
                         i, sum, cout, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (state_dbg !== IDLE || in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_idle_after_handshake: state=%0d in_ready=%b busy=%b, expected 0 1 0",
                     state_dbg, in_ready, busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (state_dbg !== RUN || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_accept_first_idle: state=%0d busy=%b, expected 1 1", state_dbg, busy);
        end
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || sum !== 16'h0005 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_second_result: out_valid=%b sum=%h cout=%b, expected 1 0005 0",
                     out_valid, sum, cout);
        end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        a        = 16'hABCD;
        b        = 16'h1111;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);   // accept edge passed
        in_valid = 1'b0;
        repeat (2) @(negedge clk);  // two nibbles written
        tests_run++;
        if (sum[7:0] !== 8'hDE || state_dbg !== RUN) begin
            tests_failed++;
            $display("FAIL rst_pre_check: sum=%h state=%0d, expected low byte DE state 1", sum, state_dbg);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (state_dbg !== IDLE || out_valid !== 1'b0 || sum !== 16'h0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_run: state=%0d out_valid=%b sum=%h busy=%b, expected 0 0 0000 0",
                     state_dbg, out_valid, sum, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || state_dbg !== IDLE) begin
            tests_failed++;
            $display("FAIL rst_no_partial: out_valid=%b state=%0d, expected 0 0", out_valid, state_dbg);
        end
        run_op("after_reset_1_plus_1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    endtask

    task automatic test_out_ready_ignored();
        int lat;
        // out_ready high from the start must not skip DONE or drop the result.
        out_ready = 1'b1;
        issue(16'h0100, 16'h0200, 1'b0, lat);
        tests_run++;
        if (lat !== 5 || sum !== 16'h0300 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL out_ready_early: lat=%0d sum=%h cout=%b, expected 5 0300 0", lat, sum, cout);
        end
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || state_dbg !== IDLE) begin
            tests_failed++;
            $display("FAIL out_ready_early_idle: out_valid=%b state=%0d, expected 0 0", out_valid, state_dbg);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add_basic();
        test_carry_ripple();
        test_cin();
        test_backpressure();
        test_reset_mid_run();
        test_out_ready_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
